// File: rtl/ibex_multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes, FSM states
// and a helper that tells divide operations apart from multiplies.
package ibex_multdiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } md_state_e;

    // All divide/remainder codes live in the upper half of the encoding.
    function automatic logic is_div(md_op_e op);
        return (op >= OP_DIV);
    endfunction

endpackage

// File: rtl/ibex_multdiv_negate.sv
// Conditional two's-complement negator: passes the operand through unless negate is set.
module ibex_multdiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             negate,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~operand + WIDTH'(1)) : operand;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with its own adder and operand registers, a valid/ready
// request/response handshake, kill support and a small-quotient divide early-out.
module ibex_multdiv_iter
    import ibex_multdiv_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MUL_STEP      = 4,
    parameter bit DIV_EARLY_OUT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_CYCLES = CNT_W'(WIDTH / MUL_STEP);
    localparam logic [CNT_W-1:0] DIV_CYCLES = CNT_W'(WIDTH);

    if ((WIDTH < 8) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("ibex_multdiv_iter: WIDTH must be even and >= 8");
    end
    if ((MUL_STEP != 1) && (MUL_STEP != 2) && (MUL_STEP != 4) && (MUL_STEP != 8)) begin : g_bad_step
        $error("ibex_multdiv_iter: MUL_STEP must be 1, 2, 4 or 8");
    end else if ((WIDTH % MUL_STEP) != 0) begin : g_bad_step_div
        $error("ibex_multdiv_iter: MUL_STEP must divide WIDTH");
    end

    md_state_e          state_q, state_d;
    md_op_e             op_q;
    logic               sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   a_q, b_q, quot_q, rem_q, result_q;
    logic [PW-1:0]      prod_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept, sign_a, sign_b, early_out, last_step;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign req_ready_o = (state_q == ST_IDLE) & ~kill_i & ~rst_i;
    assign accept      = req_valid_i & req_ready_o;
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = (state_q == ST_DONE);
    assign result_o    = result_q;
    assign last_step   = (cnt_q <= CNT_W'(1));

    assign sign_a = op_a_i[WIDTH-1] & ((operator_i == OP_MULH) | (operator_i == OP_MULHSU) |
                                       (operator_i == OP_DIV)  | (operator_i == OP_REM));
    assign sign_b = op_b_i[WIDTH-1] & ((operator_i == OP_MULH) | (operator_i == OP_DIV) |
                                       (operator_i == OP_REM));

    ibex_multdiv_negate #(.WIDTH(WIDTH)) u_neg_a (
        .negate  (sign_a),
        .operand (op_a_i),
        .result  (mag_a)
    );

    ibex_multdiv_negate #(.WIDTH(WIDTH)) u_neg_b (
        .negate  (sign_b),
        .operand (op_b_i),
        .result  (mag_b)
    );

    assign early_out = DIV_EARLY_OUT & ~data_ind_timing_i & ((mag_b == '0) | (mag_a < mag_b));

    // Multiply step: add digit * |a| into the upper half, then shift the whole product right.
    logic [MUL_STEP-1:0]       digit;
    logic [WIDTH+MUL_STEP-1:0] partial, acc;
    logic [PW-1:0]             prod_step;

    always_comb begin
        digit     = prod_q[MUL_STEP-1:0];
        partial   = {{MUL_STEP{1'b0}}, a_q} * {{WIDTH{1'b0}}, digit};
        acc       = {{MUL_STEP{1'b0}}, prod_q[PW-1:WIDTH]} + partial;
        prod_step = PW'({acc, prod_q[WIDTH-1:0]} >> MUL_STEP);
    end

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] diff;
    logic             quot_bit;
    logic [WIDTH-1:0] rem_step;

    always_comb begin
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, b_q};
        quot_bit  = ~diff[WIDTH+1];
        rem_step  = WIDTH'(quot_bit ? diff : {1'b0, rem_shift});
    end

    // A zero divisor leaves the all-ones quotient un-negated.
    logic             fix_neg;
    logic [PW-1:0]    fix_in, fix_out;
    logic [WIDTH-1:0] fix_res;

    always_comb begin
        fix_in  = prod_q;
        fix_neg = sign_a_q ^ sign_b_q;
        if (is_div(op_q)) begin
            fix_in  = {{WIDTH{1'b0}}, (op_q[1] ? rem_q : quot_q)};
            fix_neg = op_q[1] ? sign_a_q : ((sign_a_q ^ sign_b_q) & (b_q != '0));
        end
    end

    ibex_multdiv_negate #(.WIDTH(PW)) u_neg_fix (
        .negate  (fix_neg),
        .operand (fix_in),
        .result  (fix_out)
    );

    assign fix_res = (is_div(op_q) || (op_q == OP_MUL)) ? fix_out[WIDTH-1:0] : fix_out[PW-1:WIDTH];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (accept) state_d = is_div(operator_i) ? (early_out ? ST_FIXUP : ST_DIV) : ST_MUL;
            ST_MUL, ST_DIV: if (last_step) state_d = ST_FIXUP;
            ST_FIXUP:       state_d = ST_DONE;
            ST_DONE:        if (res_ready_i) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (kill_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q <= (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
            if (accept) begin
                op_q     <= operator_i;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                a_q      <= mag_a;
                b_q      <= mag_b;
                prod_q   <= {{WIDTH{1'b0}}, mag_b};
                quot_q   <= early_out ? {WIDTH{mag_b == '0}} : mag_a;
                rem_q    <= early_out ? mag_a : '0;
                cnt_q    <= is_div(operator_i) ? DIV_CYCLES : MUL_CYCLES;
            end
            if (state_q == ST_MUL) prod_q <= prod_step;
            if (state_q == ST_DIV) begin
                quot_q <= {quot_q[WIDTH-2:0], quot_bit};
                rem_q  <= rem_step;
            end
            if (state_q == ST_FIXUP) result_q <= fix_res;
            if (kill_i && (state_q != ST_IDLE)) result_q <= '0;
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed-vector bench for ibex_multdiv_iter: the driver queues expected result and first-valid
// cycle per request, and an independent monitor compares them when res_valid_o rises.
module tb_ibex_multdiv_iter;
    import ibex_multdiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    md_op_e       operator = OP_MUL;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         dit = 1'b0;
    logic         kill = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] result;
    logic         busy;

    ibex_multdiv_iter #(.WIDTH(W), .MUL_STEP(4), .DIV_EARLY_OUT(1'b1)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .operator_i        (operator),
        .op_a_i            (op_a),
        .op_b_i            (op_b),
        .data_ind_timing_i (dit),
        .kill_i            (kill),
        .res_valid_o       (res_valid),
        .res_ready_i       (res_ready),
        .result_o          (result),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the result and the cycle of the first res_valid_o of every response.
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got result %h at cycle %0d, expected no response", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, "_result"}, result, mon_e.res);
                checkOutput({mon_e.name, "_latency"}, cyc, mon_e.due);
            end
        end
        prev_valid <= res_valid;
    end

    task automatic applyStimulus(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic t, input logic [W-1:0] exp_res, input int lat,
                                 input string name, input bit track, output int t0);
        int waited;
        waited = 0;
        @(negedge clk);
        operator  = op;
        op_a      = a;
        op_b      = b;
        dit       = t;
        req_valid = 1'b1;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_accept: got req_ready 0 after %0d cycles, expected 1", name, waited);
            req_valid = 1'b0;
            t0 = -1;
            return;
        end
        t0 = cyc;
        if (track) sb.push_back('{exp_res, t0 + lat, name});
        @(negedge clk);
        req_valid = 1'b0;
        operator  = OP_REMU;
        op_a      = 32'hDEAD_BEEF;
        op_b      = 32'h1234_5678;
        dit       = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int waited;
        waited = 0;
        while ((sb.size() != 0 || busy) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending responses, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic runOp(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic t, input logic [W-1:0] exp_res, input int lat, input string name);
        int t0;
        applyStimulus(op, a, b, t, exp_res, lat, name, 1'b1, t0);
        waitIdle(name);
    endtask

    initial begin
        int t0;
        int waited;

        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset_result",    result, 32'd0);
        checkOutput("reset_busy",      {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_ready",  {31'd0, req_ready}, 32'd1);

        runOp(OP_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 10, "mulh_min_min");
        runOp(OP_MUL,    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 10, "mul_min_min");
        runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 10, "mulhsu_ones");
        runOp(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 10, "mulhu_ones");
        runOp(OP_MUL,    32'hFFFF_FFFD, 32'd5,         1'b0, 32'hFFFF_FFF1, 10, "mul_neg3_5");
        runOp(OP_MULH,   32'hFFFF_FFFD, 32'd5,         1'b0, 32'hFFFF_FFFF, 10, "mulh_neg3_5");

        runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 34, "div_overflow");
        runOp(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 34, "rem_overflow");
        runOp(OP_DIV,  32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD, 34, "div_neg7_2");
        runOp(OP_REM,  32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF, 34, "rem_neg7_2");
        runOp(OP_DIV,  32'd100,       32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 34, "div_100_neg7");
        runOp(OP_REM,  32'd100,       32'hFFFF_FFF9, 1'b0, 32'd2,         34, "rem_100_neg7");
        runOp(OP_DIVU, 32'd100,       32'd7,         1'b0, 32'd14,        34, "divu_100_7");
        runOp(OP_REMU, 32'd100,       32'd7,         1'b0, 32'd2,         34, "remu_100_7");

        runOp(OP_DIVU, 32'd7,         32'd0,  1'b0, 32'hFFFF_FFFF, 2,  "divu_7_0_early");
        runOp(OP_REM,  32'hFFFF_FFF9, 32'd0,  1'b0, 32'hFFFF_FFF9, 2,  "rem_neg7_0_early");
        runOp(OP_DIVU, 32'd7,         32'd0,  1'b1, 32'hFFFF_FFFF, 34, "divu_7_0_fixed");
        runOp(OP_DIV,  32'hFFFF_FFF9, 32'd0,  1'b1, 32'hFFFF_FFFF, 34, "div_neg7_0_fixed");
        runOp(OP_DIVU, 32'd3,         32'd10, 1'b0, 32'd0,         2,  "divu_3_10_early");
        runOp(OP_REMU, 32'd3,         32'd10, 1'b0, 32'd3,         2,  "remu_3_10_early");
        runOp(OP_REMU, 32'd3,         32'd10, 1'b1, 32'd3,         34, "remu_3_10_fixed");

        // Backpressure: hold the response in DONE for five cycles.
        res_ready = 1'b0;
        applyStimulus(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd1, 10, "bp_mulhu", 1'b1, t0);
        waited = 0;
        while (!res_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid",     {31'd0, res_valid}, 32'd1);
            checkOutput("bp_hold_result",    result, 32'd1);
            checkOutput("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("bp_release_valid",     {31'd0, res_valid}, 32'd0);
        waitIdle("bp");

        // kill_i while idle blocks acceptance.
        kill = 1'b1;
        #1;
        checkOutput("kill_idle_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        kill = 1'b0;

        // kill_i mid-divide drops the operation.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 0, "kill_div", 1'b0, t0);
        while (cyc < t0 + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_busy",  {31'd0, busy}, 32'd0);
        checkOutput("kill_valid", {31'd0, res_valid}, 32'd0);
        repeat (30) @(negedge clk);
        runOp(OP_MUL, 32'd3, 32'd5, 1'b0, 32'd15, 10, "mul_after_kill");

        // Synchronous reset mid-multiply.
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 0, "rst_mul", 1'b0, t0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_mid_result",    result, 32'd0);
        checkOutput("rst_mid_busy",      {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_after_req_ready", {31'd0, req_ready}, 32'd1);
        runOp(OP_MUL, 32'd7, 32'd9, 1'b0, 32'd63, 10, "mul_after_rst");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
